// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the conv stream host.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Backpressure LFSR: x^16 + x^14 + x^13 + x^11, Fibonacci form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Number of valid-convolution outputs for a given x and filter length
    function automatic int result_count(input int size_x, input int size_f);
        return size_x - size_f + 1;
    endfunction

endpackage

// File: rtl/conv_stream_host_mem.sv
// conv_stream_host_mem: single-port synchronous RAM, read-before-write,
// registered read data held while en is low.
module conv_stream_host_mem #(
    parameter int W     = 12,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Read returns the old word when the same address is written this cycle
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_stream_host.sv
// conv_stream_host: host-side wrapper around a 1-D convolution core.
// Streams a preloaded x vector out on x_valid/x_ready and captures the
// y result stream into a readable result memory.
// Optional CONV_HOST_STALL_EN: an LFSR throttles x_valid and y_ready
// during RUN to exercise core backpressure.
module conv_stream_host
    import conv_pkg::*;
#(
    parameter int T      = 12,
    parameter int SIZE_X = 16,
    parameter int SIZE_F = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                ld_wr_en,
    input  logic [$clog2(SIZE_X)-1:0]           ld_addr,
    input  logic [T-1:0]                        ld_data,
    input  logic                                start,
    output logic [T-1:0]                        x_data,
    output logic                                x_valid,
    input  logic                                x_ready,
    input  logic [T-1:0]                        y_data,
    input  logic                                y_valid,
    output logic                                y_ready,
    input  logic [$clog2(SIZE_X-SIZE_F+1)-1:0]  rd_addr,
    output logic [T-1:0]                        rd_data,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(SIZE_X-SIZE_F+2)-1:0]  y_count
);

    localparam int NY  = result_count(SIZE_X, SIZE_F);
    localparam int XAW = $clog2(SIZE_X);
    localparam int XCW = $clog2(SIZE_X + 1);
    localparam int RAW = $clog2(NY);
    localparam int YCW = $clog2(NY + 1);

    state_t         state, state_nxt;
    logic [XCW-1:0] xs;        // x beats accepted this run
    logic [YCW-1:0] yr;        // y beats accepted this run
    logic           pend;      // x memory read data holds element xs, not yet sent
    logic           y_stall;
    logic           x_beat, y_beat;

    logic           xm_en, xm_we;
    logic [XAW-1:0] xm_addr;
    logic [T-1:0]   xm_rdata;
    logic           rm_en, rm_we;
    logic [RAW-1:0] rm_addr;

`ifdef CONV_HOST_STALL_EN
    logic [15:0] lfsr;
    logic        shown;

    // LFSR advances only while streaming; shown marks an offer still outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr  <= LFSR_SEED;
            shown <= 1'b0;
        end else begin
            if (state == RUN) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            shown <= x_valid & ~x_ready;
        end
    end

    assign x_valid = pend & (shown | ~lfsr[0]);
    assign y_stall = lfsr[1];
`else
    assign x_valid = pend;
    assign y_stall = 1'b0;
`endif

    assign x_beat  = x_valid & x_ready;
    assign y_ready = (state == RUN) && (yr != YCW'(NY)) && !y_stall;
    assign y_beat  = y_valid & y_ready;
    assign x_data  = x_valid ? xm_rdata : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);
    assign y_count = yr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: single-cycle PRIME and FINISH around the streaming phase
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PRIME;
            PRIME:   state_nxt = RUN;
            RUN:     if (xs == XCW'(SIZE_X) && yr == YCW'(NY)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port muxing: loads in IDLE, prefetch of next x on each accepted beat
    always_comb begin
        xm_en   = 1'b0;
        xm_we   = 1'b0;
        xm_addr = ld_addr;
        rm_en   = 1'b1;
        rm_we   = 1'b0;
        rm_addr = rd_addr;
        case (state)
            IDLE: begin
                xm_en = ld_wr_en;
                xm_we = ld_wr_en;
            end
            PRIME: begin
                xm_en   = 1'b1;
                xm_addr = '0;
            end
            RUN: begin
                xm_en   = x_beat && (xs < XCW'(SIZE_X - 1));
                xm_addr = XAW'(xs + XCW'(1));
                rm_en   = y_beat;
                rm_we   = y_beat;
                rm_addr = RAW'(yr);
            end
            default: ;
        endcase
    end

    // Run counters and the prefetch-valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            xs   <= '0;
            yr   <= '0;
            pend <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    xs   <= '0;
                    yr   <= '0;
                    pend <= 1'b0;
                end
                PRIME: pend <= 1'b1;
                RUN: begin
                    if (x_beat) begin
                        xs   <= xs + XCW'(1);
                        pend <= (xs < XCW'(SIZE_X - 1));
                    end
                    if (y_beat) yr <= yr + YCW'(1);
                end
                default: ;
            endcase
        end
    end

    conv_stream_host_mem #(.W(T), .DEPTH(SIZE_X), .AW(XAW)) u_xmem (
        .clk   (clk),
        .en    (xm_en),
        .we    (xm_we),
        .addr  (xm_addr),
        .wdata (ld_data),
        .rdata (xm_rdata)
    );

    conv_stream_host_mem #(.W(T), .DEPTH(NY), .AW(RAW)) u_rmem (
        .clk   (clk),
        .en    (rm_en),
        .we    (rm_we),
        .addr  (rm_addr),
        .wdata (y_data),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_conv_stream_host.sv
// tb_conv_stream_host: randomized bench with a run-level reference model.
module tb_conv_stream_host;

    localparam int T = 12, SIZE_X = 16, SIZE_F = 4, NY = SIZE_X - SIZE_F + 1;
    localparam int AW = $clog2(SIZE_X), RW = $clog2(NY), CW = $clog2(NY + 1);

    logic          clk = 0, reset = 1, ld_wr_en = 0, start = 0, x_ready = 0, y_valid = 0;
    logic [AW-1:0] ld_addr = '0;
    logic [T-1:0]  ld_data = '0, y_data = '0;
    logic [RW-1:0] rd_addr = '0;
    logic [T-1:0]  x_data, rd_data;
    logic          x_valid, y_ready, busy, done;
    logic [CW-1:0] y_count;

    conv_stream_host #(.T(T), .SIZE_X(SIZE_X), .SIZE_F(SIZE_F)) dut (
        .clk(clk), .reset(reset), .ld_wr_en(ld_wr_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .y_count(y_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory images plus run progress counters
    logic [T-1:0] xmem [SIZE_X];
    logic [T-1:0] rmem [NY];
    bit           rvld [NY];
    logic [T-1:0] xexp [SIZE_X];
    bit           m_known = 0, m_run = 0, m_fin = 0;
    int           m_age = 0, m_xs = 0, m_yr = 0;
    int           cyc = 0, run_start = -100, first_xv = -1, last_xv = -1, done_cnt = 0;
    logic         xv18 = 1'b1;
    bit           mon_yb = 0, rd_pend = 0, prev_stall = 0;
    logic [T-1:0] rd_exp, prev_xd;
    logic [T-1:0] xgot [$];
    logic [T-1:0] ysrc [$];
    int           x_mode = 0, pc = 0;

    // Compare outputs against the model every cycle, then advance the model
    always @(negedge clk) begin
        bit exv, eyr, xb, yb;
        cyc++;
        exv = m_run && m_age >= 2 && !m_fin && m_xs < SIZE_X;
        eyr = m_run && m_age >= 2 && !m_fin && m_yr < NY;
        if (m_known) begin
            chk("busy", busy, m_run);
            chk("done", done, m_fin);
            chk("x_valid", x_valid, exv);
            chk("y_ready", y_ready, eyr);
            chk("y_count", y_count, m_yr);
            if (exv) chk("x_data", x_data, xmem[m_xs]);
            if (prev_stall) chk("x_hold", x_data, prev_xd);
            if (rd_pend) chk("rd_data", rd_data, rd_exp);
            if (done) done_cnt++;
            if (x_valid && first_xv < 0) first_xv = cyc;
            if (x_valid) last_xv = cyc;
            if (cyc == run_start + 18) xv18 = x_valid;
        end
        xb = exv && x_ready && !reset;
        yb = eyr && y_valid && !reset;
        mon_yb = yb;
        prev_stall = exv && !x_ready && !reset;
        prev_xd = x_data;
        rd_pend = 0;
        if (xb) xgot.push_back(x_data);
        if (reset) begin
            m_known = 1; m_run = 0; m_fin = 0; m_xs = 0; m_yr = 0;
        end else if (!m_run) begin
            if (rd_addr < NY && rvld[rd_addr]) begin rd_pend = 1; rd_exp = rmem[rd_addr]; end
            if (ld_wr_en) xmem[ld_addr] = ld_data;
            if (start) begin
                m_run = 1; m_age = 1; m_xs = 0; m_yr = 0;
                run_start = cyc; first_xv = -1;
            end
        end else if (m_fin) begin
            m_run = 0; m_fin = 0;
        end else begin
            if (m_age >= 2 && m_xs == SIZE_X && m_yr == NY) m_fin = 1;
            if (xb) m_xs++;
            if (yb) begin rmem[m_yr] = y_data; rvld[m_yr] = 1; m_yr++; end
            m_age++;
        end
    end

    // x_ready driver: 0 tied high, 1 repeating 1,0,0,1, else random
    always @(posedge clk) begin
        #1;
        pc++;
        case (x_mode)
            0:       x_ready = 1'b1;
            1:       x_ready = (pc % 4 == 0) || (pc % 4 == 3);
            default: x_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // y source: offers queued words with random gaps, holds until accepted
    always @(posedge clk) begin
        logic [T-1:0] dmy;
        #1;
        if (mon_yb && ysrc.size() > 0) begin dmy = ysrc.pop_front(); y_valid = 1'b0; end
        if (ysrc.size() == 0) y_valid = 1'b0;
        else begin
            y_data = ysrc[0];
            if (!y_valid) y_valid = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input int a, input int d);
        ld_wr_en = 1; ld_addr = AW'(a); ld_data = T'(d);
        tick();
        ld_wr_en = 0;
    endtask

    task automatic setup(input int mode, input int ybase, input int ny);
        @(negedge clk); #1;
        x_mode = mode;
        ysrc.delete();
        xgot.delete();
        for (int i = 0; i < ny; i++) ysrc.push_back(T'(ybase + i));
    endtask

    task automatic run(input int mode, input int ybase, input int ny, input bit poke);
        int d0;
        setup(mode, ybase, ny);
        d0 = done_cnt;
        tick(); start = 1; tick(); start = 0;
        if (poke) begin
            repeat (4) tick();
            start = 1; ld_wr_en = 1; ld_addr = '0; ld_data = 12'h7FF;
            tick();
            start = 0; ld_wr_en = 0;
        end
        for (int k = 0; k < 400 && done_cnt == d0; k++) tick();
        repeat (3) tick();
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic check_xseq(input int n);
        chk("x_beats", xgot.size(), n);
        for (int i = 0; i < n && i < xgot.size(); i++) chk("x_order", xgot[i], xexp[i]);
    endtask

    task automatic readback(input int base);
        for (int i = 0; i < NY; i++) begin
            rd_addr = RW'(i);
            tick();
            chk("rd_lit", rd_data, T'(base + i));
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_x_valid", x_valid, 0);
        chk("rst_y_ready", y_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y_count", y_count, 0);
        chk("rst_x_data", x_data, 0);
        reset = 0;
        for (int i = 0; i < SIZE_X; i++) begin xexp[i] = T'(i + 1); load(i, i + 1); end

        // Tied-ready streaming, 13 results plus one surplus offered beat
        run(0, 100, 14, 0);
        check_xseq(SIZE_X);
        chk("x_valid_latency", first_xv - run_start, 2);
        chk("last_valid_cycle", last_xv - run_start, 17);
        chk("x_valid_low_at_18", xv18, 0);
        chk("y_count_lit", y_count, 13);
        chk("surplus_y_refused", ysrc.size(), 1);
        readback(100);

        // 1,0,0,1 backpressure
        run(1, 200, 13, 0);
        check_xseq(SIZE_X);
        readback(200);

        // Reset after five x beats, then a fresh run resends from element 0
        setup(0, 300, 13);
        tick(); start = 1; tick(); start = 0;
        for (int k = 0; k < 50 && xgot.size() < 5; k++) tick();
        reset = 1; tick(); reset = 0;
        chk("abort_x_valid", x_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_y_count", y_count, 0);
        check_xseq(5);
        run(2, 400, 13, 0);
        check_xseq(SIZE_X);
        readback(400);

        // start and load during RUN are ignored
        run(1, 500, 13, 1);
        check_xseq(SIZE_X);
        run(2, 600, 13, 0);
        check_xseq(SIZE_X);
        readback(600);

        // Random x contents under random backpressure
        for (int i = 0; i < SIZE_X; i++) begin
            int v;
            v = int'($urandom_range(0, 4095));
            xexp[i] = T'(v);
            load(i, v);
        end
        run(2, 700, 13, 0);
        check_xseq(SIZE_X);
        readback(700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
